// File: rtl/global_params.sv
// Mesh-wide constants and the link flit layout shared by every router block.
package global_params;

  localparam int unsigned MESH_SIDE = 3;
  localparam int unsigned COORD_W   = $clog2(MESH_SIDE);
  localparam int unsigned PAYLOAD_W = 8;
  localparam int unsigned FLIT_W    = 2 * COORD_W + PAYLOAD_W;

  typedef struct packed {
    logic [COORD_W-1:0]   dest_x;
    logic [COORD_W-1:0]   dest_y;
    logic [PAYLOAD_W-1:0] payload;
  } flit_t;

endpackage

// File: rtl/in_port_buffer_if.sv
// Link-side valid/ready handshake carrying flits into a router input port.
interface in_port_buffer_if;
  import global_params::*;

  flit_t in_flit;
  logic  in_valid;
  logic  in_ready;

  modport master (output in_flit, output in_valid, input in_ready);
  modport slave  (input in_flit, input in_valid, output in_ready);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; push is refused when full and pop when empty.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [Width-1:0]           wdata,
  input  logic                       pop,
  output logic [Width-1:0]           rdata,
  output logic [$clog2(Depth+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = $clog2(Depth + 1);

  logic [Width-1:0] mem [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == '0);
  // No bypass: a full FIFO refuses a push even while it is being popped.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      if (do_push && !do_pop) begin
        count_q <= count_q + CntW'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

  assign rdata = mem[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/in_port_buffer.sv
// Router input port: buffers link flits, drops malformed ones and decodes the head's route hints.
module in_port_buffer
  import global_params::flit_t, global_params::FLIT_W;
#(
  parameter int unsigned X_COORD   = 1,
  parameter int unsigned Y_COORD   = 1,
  parameter int unsigned MESH_SIDE = global_params::MESH_SIDE,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  in_port_buffer_if.slave               link,
  output logic [$clog2(MESH_SIDE)-1:0]  dest_x,
  output logic [$clog2(MESH_SIDE)-1:0]  dest_y,
  output logic                          s_delta_x,
  output logic                          s_delta_y,
  output logic                          valid,
  output flit_t                         out_flit,
  input  logic                          grant,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          drop
);

  localparam int unsigned CoordW = $clog2(MESH_SIDE);

  flit_t head;
  logic  fifo_full, fifo_empty;
  logic  accept, malformed, push, pop;
  logic  drop_q;

  assign link.in_ready = ~fifo_full;
  assign accept        = link.in_valid & link.in_ready;
  assign malformed     = (32'(link.in_flit.dest_x) >= MESH_SIDE) ||
                         (32'(link.in_flit.dest_y) >= MESH_SIDE);
  assign push          = accept & ~malformed;
  assign valid         = ~fifo_empty;
  assign pop           = grant & valid;

  sync_fifo #(
    .Width (FLIT_W),
    .Depth (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (link.in_flit),
    .pop   (pop),
    .rdata (head),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Malformed flits are still handshaken so the link never stalls on them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_q <= 1'b0;
    else     drop_q <= accept & malformed;
  end
  assign drop = drop_q;

  // Stale storage must not leak out while the buffer is empty.
  always_comb begin
    out_flit  = '0;
    dest_x    = '0;
    dest_y    = '0;
    s_delta_x = 1'b0;
    s_delta_y = 1'b0;
    if (valid) begin
      out_flit  = head;
      dest_x    = CoordW'(head.dest_x);
      dest_y    = CoordW'(head.dest_y);
      s_delta_x = (32'(head.dest_x) < X_COORD);
      s_delta_y = (32'(head.dest_y) < Y_COORD);
    end
  end

endmodule

// File: tb/tb_in_port_buffer.sv
// Scenario bench for in_port_buffer: a flit queue models the buffer and checks order and decode.
module tb_in_port_buffer;
  import global_params::*;

  localparam int unsigned XC    = 1;
  localparam int unsigned YC    = 1;
  localparam int unsigned MS    = 3;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CntW  = $clog2(DEPTH + 1);

  logic               clk = 1'b0;
  logic               rst;
  logic               grant;
  logic [COORD_W-1:0] dest_x, dest_y;
  logic               s_delta_x, s_delta_y, valid, drop;
  flit_t              out_flit;
  logic [CntW-1:0]    count;

  in_port_buffer_if bus ();

  in_port_buffer #(
    .X_COORD   (XC),
    .Y_COORD   (YC),
    .MESH_SIDE (MS),
    .DEPTH     (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .link      (bus.slave),
    .dest_x    (dest_x),
    .dest_y    (dest_y),
    .s_delta_x (s_delta_x),
    .s_delta_y (s_delta_y),
    .valid     (valid),
    .out_flit  (out_flit),
    .grant     (grant),
    .count     (count),
    .drop      (drop)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad   = 0;
  flit_t sb[$];
  logic  did_pop, exp_drop, exp_ready, pre_ready;
  flit_t pop_got, pop_exp;

  function automatic flit_t mk(input int x, input int y, input int p);
    flit_t f;
    f.dest_x  = COORD_W'(x);
    f.dest_y  = COORD_W'(y);
    f.payload = PAYLOAD_W'(p);
    return f;
  endfunction

  // One clock of stimulus; updates the model queue and records what was popped.
  task automatic drive(input logic iv, input flit_t f, input logic g);
    logic acc, mal;
    bus.in_valid = iv;
    bus.in_flit  = f;
    grant        = g;
    #1;
    exp_ready = (sb.size() != DEPTH);
    pre_ready = bus.in_ready;
    acc       = iv && exp_ready;
    mal       = (int'(f.dest_x) >= MS) || (int'(f.dest_y) >= MS);
    did_pop   = g && (sb.size() != 0);
    pop_got   = out_flit;
    if (did_pop) pop_exp = sb.pop_front();
    if (acc && !mal) sb.push_back(f);
    exp_drop  = acc && mal;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    grant        = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.in_valid = 1'b0; bus.in_flit = '0; grant = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (count !== '0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", bus.in_ready); end
    total++; if (drop !== 1'b0) begin bad++; $display("FAIL rst_drop got=%b exp=0", drop); end
    total++; if (out_flit !== '0) begin bad++; $display("FAIL rst_flit got=%h exp=0", out_flit); end
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_decode();
    drive(1'b1, mk(0, 2, 'hA5), 1'b0);
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL dec_valid got=%b exp=1", valid); end
    total++; if (s_delta_x !== 1'b1) begin bad++; $display("FAIL dec_sdx got=%b exp=1", s_delta_x); end
    total++; if (s_delta_y !== 1'b0) begin bad++; $display("FAIL dec_sdy got=%b exp=0", s_delta_y); end
    total++; if (count !== CntW'(1)) begin bad++; $display("FAIL dec_count got=%0d exp=1", count); end
    total++; if (dest_x !== 2'd0 || dest_y !== 2'd2) begin
      bad++; $display("FAIL dec_dest got=%0d,%0d exp=0,2", dest_x, dest_y);
    end
    drive(1'b0, '0, 1'b1);
    total++; if (!did_pop || pop_got !== pop_exp) begin
      bad++; $display("FAIL dec_pop got=%h exp=%h", pop_got, pop_exp);
    end
    total++; if (valid !== 1'b0 || out_flit !== '0 || dest_y !== '0 || s_delta_x !== 1'b0) begin
      bad++; $display("FAIL dec_empty got=%b/%h/%0d/%b exp=0/0/0/0", valid, out_flit, dest_y, s_delta_x);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, mk(i % 3, (i + 1) % 3, 'h10 + i), 1'b0);
      total++; if (count !== CntW'(sb.size())) begin
        bad++; $display("FAIL fill_count got=%0d exp=%0d", count, sb.size());
      end
      total++; if (out_flit !== sb[0]) begin
        bad++; $display("FAIL fill_head got=%h exp=%h", out_flit, sb[0]);
      end
    end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", bus.in_ready); end
    drive(1'b1, mk(1, 1, 'hEE), 1'b0);
    total++; if (pre_ready !== exp_ready) begin
      bad++; $display("FAIL full_offer_ready got=%b exp=%b", pre_ready, exp_ready);
    end
    total++; if (count !== CntW'(DEPTH)) begin bad++; $display("FAIL full_count got=%0d exp=%0d", count, DEPTH); end
  endtask

  task automatic test_drain();
    // The first cycle also offers a flit: full with grant must still refuse it.
    drive(1'b1, mk(2, 2, 'h77), 1'b1);
    total++; if (pre_ready !== 1'b0) begin bad++; $display("FAIL drain_bypass got=%b exp=0", pre_ready); end
    total++; if (!did_pop || pop_got !== pop_exp) begin
      bad++; $display("FAIL drain_pop0 got=%h exp=%h", pop_got, pop_exp);
    end
    for (int i = 1; i < 4; i++) begin
      drive(1'b0, '0, 1'b1);
      total++; if (!did_pop || pop_got !== pop_exp) begin
        bad++; $display("FAIL drain_pop%0d got=%h exp=%h", i, pop_got, pop_exp);
      end
    end
    total++; if (count !== '0 || valid !== 1'b0) begin
      bad++; $display("FAIL drain_end got=%0d/%b exp=0/0", count, valid);
    end
  endtask

  task automatic test_drop();
    drive(1'b1, mk(3, 0, 'h33), 1'b0);
    total++; if (drop !== exp_drop || drop !== 1'b1) begin bad++; $display("FAIL drop_pulse got=%b exp=1", drop); end
    total++; if (count !== '0) begin bad++; $display("FAIL drop_count got=%0d exp=0", count); end
    drive(1'b0, '0, 1'b0);
    total++; if (drop !== 1'b0) begin bad++; $display("FAIL drop_width got=%b exp=0", drop); end
    drive(1'b1, mk(0, 3, 'h44), 1'b0);
    total++; if (drop !== 1'b1 || count !== '0) begin
      bad++; $display("FAIL drop_y got=%b/%0d exp=1/0", drop, count);
    end
  endtask

  task automatic test_simul();
    drive(1'b1, mk(0, 0, 'h51), 1'b0);
    drive(1'b1, mk(1, 2, 'h52), 1'b0);
    drive(1'b1, mk(2, 1, 'h53), 1'b1);
    total++; if (!did_pop || pop_got !== pop_exp) begin
      bad++; $display("FAIL simul_pop got=%h exp=%h", pop_got, pop_exp);
    end
    total++; if (count !== CntW'(2)) begin bad++; $display("FAIL simul_count got=%0d exp=2", count); end
    total++; if (out_flit !== sb[0] || s_delta_y !== (int'(sb[0].dest_y) < YC)) begin
      bad++; $display("FAIL simul_head got=%h exp=%h", out_flit, sb[0]);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, mk(2, 0, 'h61), 1'b0);
    total++; if (count !== CntW'(3)) begin bad++; $display("FAIL ares_pre got=%0d exp=3", count); end
    #2 rst = 1'b1;
    #1;
    total++; if (count !== '0 || valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL ares_now got=%0d/%b/%b exp=0/0/1", count, valid, bus.in_ready);
    end
    #2 rst = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    total++; if (count !== '0 || out_flit !== '0) begin
      bad++; $display("FAIL ares_after got=%0d/%h exp=0/0", count, out_flit);
    end
  endtask

  task automatic test_random();
    flit_t f;
    for (int n = 0; n < 120; n++) begin
      f = mk($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) f.dest_x = 2'd3;
      drive(1'($urandom_range(0, 1)), f, 1'($urandom_range(0, 2) == 0));
      total++; if (pre_ready !== exp_ready) begin
        bad++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, pre_ready, exp_ready);
      end
      total++; if (did_pop && pop_got !== pop_exp) begin
        bad++; $display("FAIL rnd_order n=%0d got=%h exp=%h", n, pop_got, pop_exp);
      end
      total++; if (count !== CntW'(sb.size()) || drop !== exp_drop) begin
        bad++; $display("FAIL rnd_state n=%0d got=%0d/%b exp=%0d/%b", n, count, drop, sb.size(), exp_drop);
      end
      total++; if (out_flit !== ((sb.size() != 0) ? sb[0] : flit_t'('0))) begin
        bad++; $display("FAIL rnd_head n=%0d got=%h", n, out_flit);
      end
      total++; if (sb.size() != 0 && s_delta_x !== (int'(sb[0].dest_x) < XC)) begin
        bad++; $display("FAIL rnd_sdx n=%0d got=%b", n, s_delta_x);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    test_reset();
    test_decode();
    test_fill();
    test_drain();
    test_drop();
    test_simul();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/in_port_buffer.md
IN_PORT_BUFFER -- requirements
Module: in_port_buffer

Interface
REQ-001 The block SHALL have parameter X_COORD, default 1, the router's X coordinate.
REQ-002 The block SHALL have parameter Y_COORD, default 1, the router's Y coordinate.
REQ-003 The block SHALL have parameter MESH_SIDE, default global_params::MESH_SIDE, the mesh side length.
REQ-004 The block SHALL have parameter DEPTH, default 4, the FIFO depth; it SHALL be a power of two and at least 2.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port in_flit, input, FLIT_W bits: the link flit, {dest_x, dest_y, payload}.
REQ-008 The block SHALL have port in_valid, input, 1 bit: the link offers in_flit.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the buffer accepts this cycle.
REQ-010 The block SHALL have port dest_x, output, $clog2(MESH_SIDE) bits: the head flit's destination X.
REQ-011 The block SHALL have port dest_y, output, $clog2(MESH_SIDE) bits: the head flit's destination Y.
REQ-012 The block SHALL have port s_delta_x, output, 1 bit: 1 when the head's dest_x < X_COORD.
REQ-013 The block SHALL have port s_delta_y, output, 1 bit: 1 when the head's dest_y < Y_COORD.
REQ-014 The block SHALL have port valid, output, 1 bit: the head is present; it drives the routing block's valid.
REQ-015 The block SHALL have port out_flit, output, FLIT_W bits: the head flit, for the crossbar.
REQ-016 The block SHALL have port grant, input, 1 bit: the switch allocator consumes the head this cycle.
REQ-017 The block SHALL have port count, output, $clog2(DEPTH+1) bits: the current occupancy.
REQ-018 The block SHALL have port drop, output, 1 bit: a one-cycle pulse when a malformed flit is discarded.

Function
REQ-019 The block SHALL accept a flit when in_valid && in_ready; in_ready SHALL equal (count != DEPTH), purely from registered state.
REQ-020 The block SHALL treat a flit as malformed when its dest_x >= MESH_SIDE or its dest_y >= MESH_SIDE; a malformed flit SHALL still be handshaken but not stored, and drop SHALL be high the following cycle.
REQ-021 The block SHALL pop the head when grant && valid; grant while valid=0 SHALL be ignored.
REQ-022 The block SHALL have latency 1: a flit accepted at edge N SHALL give valid=1 from after edge N when the FIFO was empty.
REQ-023 On simultaneous push and pop, the block SHALL keep count unchanged and advance both pointers.
REQ-024 When full, in_ready SHALL be 0, even when grant is high in the same cycle (no same-cycle bypass).
REQ-025 The block SHALL wrap its pointers modulo DEPTH; count SHALL never exceed DEPTH or underflow 0.
REQ-026 The block SHALL hold s_delta_x, s_delta_y, dest_x and dest_y constant while the head is not popped.
REQ-027 When empty, the block SHALL drive dest_x, dest_y, s_delta_x, s_delta_y and out_flit to 0.
REQ-028 The block SHALL deliver flits in FIFO order with no reordering or duplication.

Reset
REQ-029 When rst is asserted, the block SHALL immediately clear pointers, count and drop, with valid=0, in_ready=1 and all head outputs 0.
REQ-030 Reset mid-operation SHALL discard all stored flits; storage contents need no reset.

Structure
REQ-031 FLIT_W, PAYLOAD_W and a packed flit_t typedef with fields dest_x, dest_y and payload SHALL live in global_params.
REQ-032 The storage and pointers SHALL be a sub-module sync_fifo, parameterised by width and depth; the header decode and drop logic SHALL live in in_port_buffer.

Verification
REQ-033 With X=1, Y=1, MESH_SIDE=3, push flit dest (0,2) into an empty buffer -> the next cycle shows valid=1, s_delta_x=1, s_delta_y=0, count=1.
REQ-034 Push 4 flits without grant -> count=4 and in_ready=0; a 5th offered flit is not accepted and the contents are unchanged.
REQ-035 When full, hold grant high for 4 cycles -> flits emerge in order, count reaches 0 and valid=0.
REQ-036 Push flit dest (3,0) -> drop pulses for exactly 1 cycle and count stays 0.
REQ-037 With count=2, push and grant in the same cycle -> count stays 2 and the head advances.
REQ-038 Assert rst asynchronously with count=3 -> count=0, valid=0 and in_ready=1 before the next edge.
